// File: rtl/aes_pkg.sv
// Shared AES constants, controller state encoding and GF(2^8) helpers
// used by the inverse-cipher datapath.
package aes_pkg;

    localparam int BLK_W  = 128;
    localparam int BYTE_W = 8;
    localparam logic [7:0] AES_POLY = 8'h1b;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } ctrl_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] acc;
        p   = gf_mul(a, a);
        acc = p;
        for (int k = 2; k < 8; k++) begin
            p   = gf_mul(p, p);
            acc = gf_mul(acc, p);
        end
        return acc;
    endfunction

    // Inverse S-box: undo the affine map, then invert in GF(2^8).
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse-cipher round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped on the last round).
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] st,
    input  logic [BLK_W-1:0] rk,
    input  logic             last,
    output logic [BLK_W-1:0] st_next
);

    logic [BLK_W-1:0] sub_s;
    logic [BLK_W-1:0] ark_s;
    logic [BLK_W-1:0] mix_s;

    // Byte (row r, col c) sits at [127-8*(r+4c)]; row r is rotated right by r columns.
    always_comb begin
        sub_s = {BLK_W{1'b0}};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub_s[127 - 8*(r + 4*c) -: 8] = inv_sbox(st[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8]);
            end
        end
    end

    assign ark_s = sub_s ^ rk;

    // Column-wise InvMixColumns on the key-mixed state.
    always_comb begin
        mix_s = {BLK_W{1'b0}};
        for (int c = 0; c < 4; c++) begin
            mix_s[127 - 32*c -: 32] = inv_mix_col(ark_s[127 - 32*c -: 32]);
        end
    end

    assign st_next = last ? ark_s : mix_s;

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES inverse-cipher sequencer: one round per clock through aes_inv_round,
// valid/ready handshakes on both sides, round keys fetched by index.
module aes_inv_cipher_ctrl
    import aes_pkg::*;
#(
    parameter int NR = NR_128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    output logic [3:0]       rk_idx,
    input  logic [BLK_W-1:0] rk,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             busy
);

    localparam logic [3:0] NR_IDX  = 4'(NR);
    localparam logic [3:0] NR_LAST = 4'(NR - 1);

    ctrl_state_e      state_r;
    logic [3:0]       rnd_r;
    logic [BLK_W-1:0] st_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;
    logic             last_s;
    logic [BLK_W-1:0] st_next_s;

    assign last_s = (rnd_r == 4'd0);

    aes_inv_round u_round (
        .st      (st_r),
        .rk      (rk),
        .last    (last_s),
        .st_next (st_next_s)
    );

    // Key index follows the state: final key while waiting, round counter otherwise.
    assign rk_idx = (state_r == ST_IDLE) ? NR_IDX : rnd_r;

    // Controller FSM, round counter, state register and handshake flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rnd_r       <= 4'd0;
            st_r        <= {BLK_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        st_r       <= in_data ^ rk;
                        rnd_r      <= NR_LAST;
                        state_r    <= ST_ROUND;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                ST_ROUND: begin
                    st_r <= st_next_s;
                    if (last_s) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        rnd_r <= rnd_r - 4'd1;
                    end
                end
                ST_DONE: begin
                    // Plaintext stays parked in st_r until the consumer takes it.
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    rnd_r       <= 4'd0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_data  = st_r;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Self-checking bench: FIPS-197 vectors plus random blocks produced by a forward-cipher model.
module tb_aes_inv_cipher_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [127:0] a_in_data, a_out_data, a_rk;
    logic [3:0]   a_rk_idx;
    logic [127:0] a_keys [0:15];
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [127:0] b_in_data, b_out_data, b_rk;
    logic [3:0]   b_rk_idx;
    logic [127:0] b_keys [0:15];
    logic [127:0] u_st, u_rk, u_nxt;
    logic         u_last;

    assign a_rk = a_keys[a_rk_idx];
    assign b_rk = b_keys[b_rk_idx];

    aes_inv_cipher_ctrl #(.NR(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .rk_idx(a_rk_idx), .rk(a_rk), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy));

    aes_inv_cipher_ctrl #(.NR(14)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .rk_idx(b_rk_idx), .rk(b_rk), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy));

    aes_inv_round u_rnd (.st(u_st), .rk(u_rk), .last(u_last), .st_next(u_nxt));

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox [0:255];
    logic [127:0] ks   [0:15];

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;
    vec_t vecs [8];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_STD = 128'h00112233445566778899aabbccddeeff;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = 15'd0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] byt(input logic [127:0] s, input int i);
        return s[127 - 8*i -: 8];
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subword(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int k = 0; k <= nr; k++) ks[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    // Forward cipher on a byte array indexed row + 4*col.
    function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = byt(pt, i) ^ byt(ks[0], i);
        for (int rd = 1; rd <= nr; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r + 4*c] = sbox[s[r + 4*((c + r) % 4)]];
            if (rd != nr) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
                    s[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
                end
            end else begin
                s = t;
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ byt(ks[rd], i);
        end
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic load_a();
        for (int k = 0; k < 16; k++) a_keys[k] = ks[k];
    endtask

    task automatic wait_a_ready(input string tag);
        int k;
        k = 0;
        while (!a_in_ready && k < 50) begin @(posedge clk); #1; k++; end
        check({tag, " ready"}, 128'(a_in_ready), 128'd1);
    endtask

    // Full transaction on instance A with optional DONE backpressure and ignored in_valid pulses.
    task automatic run_a(input logic [127:0] ct, input logic [127:0] pt, input int hold, input string tag);
        int k;
        wait_a_ready(tag);
        a_in_valid = 1'b1;
        a_in_data  = ct;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_in_data  = rnd128();
        k = 0;
        while (!a_out_valid && k < 40) begin @(posedge clk); #1; k++; end
        check({tag, " latency"}, 128'(k), 128'd10);
        check({tag, " data"}, a_out_data, pt);
        check({tag, " in_ready in DONE"}, 128'(a_in_ready), 128'd0);
        check({tag, " busy in DONE"}, 128'(a_busy), 128'd1);
        for (int h = 0; h < hold; h++) begin
            a_in_valid = h[0];
            a_in_data  = rnd128();
            @(posedge clk); #1;
            check({tag, " hold valid"}, 128'(a_out_valid), 128'd1);
            check({tag, " hold data"}, a_out_data, pt);
            check({tag, " hold in_ready"}, 128'(a_in_ready), 128'd0);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        check({tag, " back to idle"}, 128'(a_in_ready), 128'd1);
        check({tag, " valid dropped"}, 128'(a_out_valid), 128'd0);
        check({tag, " busy dropped"}, 128'(a_busy), 128'd0);
    endtask

    initial begin : main
        logic [2047:0] sbox_hex;
        logic [127:0]  t0, t1;
        int k, t_first, n_acc, n_out, n_seen;

        sbox_hex = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        for (int i = 0; i < 256; i++) sbox[i] = sbox_hex[2047 - 8*i -: 8];
        for (int i = 0; i < 16; i++) begin a_keys[i] = 128'd0; b_keys[i] = 128'd0; end

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = 128'd0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = 128'd0; b_out_ready = 1'b0;
        u_st = 128'd0; u_rk = 128'd0; u_last = 1'b0;

        // Unit check of the round datapath: pre-image makes InvShiftRows/InvSubBytes yield known columns.
        t0 = 128'h8e4da1bc_01010101_00000000_00000000;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) u_st[127 - 8*(r + 4*c) -: 8] = sbox[byt(t0, r + 4*((c + r) % 4))];
        #1;
        check("round imc", u_nxt, 128'hdb135345_01010101_00000000_00000000);
        u_last = 1'b1;
        #1;
        check("round last bypass", u_nxt, t0);

        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", 128'(a_in_ready), 128'd1);
        check("rst out_valid", 128'(a_out_valid), 128'd0);
        check("rst busy", 128'(a_busy), 128'd0);
        check("rst out_data", a_out_data, 128'd0);
        check("rst rk_idx a", 128'(a_rk_idx), 128'd10);
        check("rst rk_idx b", 128'(b_rk_idx), 128'd14);
        rst_n = 1'b1;

        vecs[0] = '{C1_KEY, C1_CT, PT_STD};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32,
                    128'h3243f6a8885a308d313198a2e0370734};
        for (int i = 2; i < 8; i++) begin
            vecs[i].key = rnd128();
            vecs[i].pt  = rnd128();
            expand({vecs[i].key, 128'd0}, 4, 10);
            vecs[i].ct  = encrypt(vecs[i].pt, 10);
        end

        for (int i = 0; i < 8; i++) begin
            expand({vecs[i].key, 128'd0}, 4, 10);
            load_a();
            run_a(vecs[i].ct, vecs[i].pt, (i == 0) ? 5 : 0, $sformatf("vec%0d", i));
        end

        // Back-to-back with in_valid and out_ready held high.
        expand({C1_KEY, 128'd0}, 4, 10);
        load_a();
        wait_a_ready("b2b");
        a_in_valid = 1'b1; a_in_data = C1_CT; a_out_ready = 1'b1;
        t_first = -1; n_acc = 0; n_out = 0; k = 0;
        while (n_out < 2 && k < 60) begin
            if (a_in_ready) begin
                n_acc++;
                if (t_first < 0) t_first = k;
                else check("b2b spacing", 128'(k - t_first), 128'd12);
            end
            if (a_out_valid) begin
                n_out++;
                check("b2b data", a_out_data, PT_STD);
                check("b2b ready excl", 128'(a_in_ready), 128'd0);
                if (n_out == 2) a_in_valid = 1'b0;
            end
            @(posedge clk); #1; k++;
        end
        check("b2b outputs", 128'(n_out), 128'd2);
        check("b2b accepts", 128'(n_acc), 128'd2);
        a_in_valid = 1'b0; a_out_ready = 1'b0;

        // Reset in the middle of round processing.
        wait_a_ready("rst mid");
        a_in_valid = 1'b1; a_in_data = C1_CT;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid rst in_ready", 128'(a_in_ready), 128'd1);
        check("mid rst out_valid", 128'(a_out_valid), 128'd0);
        check("mid rst busy", 128'(a_busy), 128'd0);
        check("mid rst out_data", a_out_data, 128'd0);
        n_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (a_out_valid) n_seen++;
        end
        check("mid rst no pulse", 128'(n_seen), 128'd0);
        run_a(C1_CT, PT_STD, 0, "after rst");

        // AES-256 build.
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
        for (int i = 0; i < 16; i++) b_keys[i] = ks[i];
        check("c3 ready", 128'(b_in_ready), 128'd1);
        b_in_valid = 1'b1; b_in_data = 128'h8ea2b7ca516745bfeafc49904b496089;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        k = 0;
        while (!b_out_valid && k < 40) begin @(posedge clk); #1; k++; end
        check("c3 latency", 128'(k), 128'd14);
        check("c3 data", b_out_data, PT_STD);
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        check("c3 idle", 128'(b_in_ready), 128'd1);

        t1 = a_out_data;
        check("a idle data held", t1, PT_STD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_inv_cipher_ctrl.md
# aes_inv_cipher_ctrl

Iterative AES decryption engine: accepts one 128-bit ciphertext block over a valid/ready handshake, runs the inverse cipher one round per clock through a single shared inverse-round datapath, and returns the plaintext over a second valid/ready handshake. Round keys are fetched by index from an external key-schedule store. Sits between the bus-facing block buffer and the key-expansion RAM, and is the sole sequencer of the InvMixColumns/InvShiftRows/InvSubBytes/AddRoundKey datapath.

## Interface
- NR, 10, number of rounds (10/12/14 for AES-128/192/256); key store must hold NR+1 keys
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low; sampled on the rising edge of clk
- in_valid  in  1  ciphertext present
- in_ready  out  1  block can accept ciphertext (high only in IDLE)
- in_data  in  128  ciphertext; [127:120] = state byte 0 (row 0, col 0), column-major, column c in [127-32c -: 32]
- rk_idx  out  4  round-key index requested (combinational from state)
- rk  in  128  round key for rk_idx, valid in the same cycle (asynchronous-read store)
- out_valid  out  1  plaintext present
- out_ready  in  1  consumer accepts plaintext
- out_data  out  128  plaintext, same byte order as in_data
- busy  out  1  high in ROUND and DONE

## Operation
- States: IDLE, ROUND, DONE. Round counter r, 4 bits. State register st, 128 bits.
- IDLE: in_ready=1, rk_idx=NR. On in_valid&&in_ready: st <= in_data ^ rk, r <= NR-1, go ROUND.
- ROUND: rk_idx=r. Each cycle st <= InvRound(st, rk, last=(r==0)), where InvRound = InvShiftRows -> InvSubBytes -> AddRoundKey(rk) -> InvMixColumns (InvMixColumns bypassed when last). If r==0 go DONE, else r <= r-1.
- DONE: out_valid=1, out_data=st. On out_ready go IDLE. st and out_data held stable while out_valid&&!out_ready.
- in_valid outside IDLE ignored; in_data not sampled. out_ready outside DONE ignored.
- InvMixColumns per column uses GF(2^8) multiplication by 0e/0b/0d/09, reduction polynomial 0x11b; all arithmetic 8-bit XOR, no carries.
- Reset (rst_n low at an edge, any state, mid-round included): state IDLE, r=0, st=0; in-flight block discarded, no out_valid pulse.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, busy=0, out_data=0, rk_idx=NR.
- Accept at edge E; ROUND occupies cycles after E through E+NR; out_valid first high in cycle after edge E+NR (latency NR+1 cycles from accept cycle to out_valid).
- Throughput with out_ready tied high: one block per NR+2 cycles (accept, NR rounds, DONE).
- rk must settle within the cycle rk_idx is driven; no registered key path.
- in_ready and out_valid never high in the same cycle.

## Structure
- Shared package aes_pkg: state/key width 128, byte width 8, AES polynomial 8'h1b, round-count constants NR_128=10, NR_192=12, NR_256=14, state-encoding enum for IDLE/ROUND/DONE.
- One combinational sub-module aes_inv_round (inputs st, rk, last; output next st) instantiating the existing InvMixColumns datapath plus InvShiftRows/InvSubBytes; controller holds only FSM, counter, state register.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f (bench model supplies rk), in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff, out_valid in cycle accept+11.
- aes_inv_round unit, last=0, rk=0: column 8e4da1bc passes InvMixColumns -> db135345; column 01010101 -> 01010101.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
- Back-to-back: two C.1 blocks with in_valid and out_ready held high -> second accepted exactly 12 cycles after the first, both outputs correct.
- Reset mid-round: assert rst_n=0 at round 5 for one edge -> next cycle in_ready=1, out_valid=0, busy=0, out_data=0; subsequent block decrypts correctly.
- NR=14 build, FIPS-197 C.3 (AES-256) vector 8ea2b7ca516745bfeafc49904b496089 -> 00112233445566778899aabbccddeeff after 15 cycles.
